// File: rtl/sobel.sv
// Streaming 3x3 Sobel edge-magnitude engine: nine pixels in, one 8-bit magnitude out.
// Define SOBEL_THRESHOLD_EN to emit a binary edge map (S >= THRESHOLD) instead.
module sobel #(
    parameter int KERNEL_MxM   = 3,
    parameter int Numb_of_Data = 9,
    parameter int THRESHOLD    = 128
) (
    input  logic       clk_i_s,
    input  logic       rstn_i_s,
    input  logic       en_i_s,
    input  logic [7:0] data_i_s,
    output logic [7:0] data_o_s,
    output logic       sobel_done
);

    localparam logic [3:0] LAST = 4'(Numb_of_Data - 1);

    generate
        if (KERNEL_MxM != 3 || Numb_of_Data != KERNEL_MxM * KERNEL_MxM
            || THRESHOLD < 0 || THRESHOLD > 2040) begin : g_bad_cfg
            $error("sobel: unsupported kernel or threshold configuration");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        LOAD,
        CALC,
        MAG,
        DONE
    } state_t;

    state_t             state_q;
    logic [3:0]         count_q;
    logic [7:0]         pix_q [Numb_of_Data];
    logic signed [10:0] gx_q;
    logic signed [10:0] gy_q;
    logic [7:0]         data_q;
    logic               done_q;

    logic [11:0] xp, xn, yp, yn;
    logic [11:0] gx_w, gy_w;
    logic [10:0] gx_d, gy_d;
    logic [11:0] ax, ay, sum_d;
    logic [7:0]  mag_d;

    assign data_o_s   = data_q;
    assign sobel_done = done_q;

    // Gradient halves are non-negative; their 12-bit difference is two's complement.
    always_comb begin
        xp   = {4'b0, pix_q[2]} + {3'b0, pix_q[5], 1'b0} + {4'b0, pix_q[8]};
        xn   = {4'b0, pix_q[0]} + {3'b0, pix_q[3], 1'b0} + {4'b0, pix_q[6]};
        yp   = {4'b0, pix_q[6]} + {3'b0, pix_q[7], 1'b0} + {4'b0, pix_q[8]};
        yn   = {4'b0, pix_q[0]} + {3'b0, pix_q[1], 1'b0} + {4'b0, pix_q[2]};
        gx_w = xp - xn;
        gy_w = yp - yn;
        gx_d = gx_w[10:0];
        gy_d = gy_w[10:0];
    end

    always_comb begin
        ax    = gx_q[10] ? (12'd0 - {gx_q[10], gx_q}) : {1'b0, gx_q};
        ay    = gy_q[10] ? (12'd0 - {gy_q[10], gy_q}) : {1'b0, gy_q};
        sum_d = ax + ay;
`ifdef SOBEL_THRESHOLD_EN
        mag_d = (sum_d >= 12'(THRESHOLD)) ? 8'hFF : 8'h00;
`else
        mag_d = (sum_d > 12'd255) ? 8'hFF : sum_d[7:0];
`endif
    end

    always_ff @(posedge clk_i_s) begin
        if (rstn_i_s) begin
            state_q <= IDLE;
            count_q <= '0;
            for (int i = 0; i < Numb_of_Data; i++) begin
                pix_q[i] <= '0;
            end
            gx_q   <= '0;
            gy_q   <= '0;
            data_q <= '0;
            done_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    count_q <= '0;
                    if (en_i_s) begin
                        state_q <= ARM;
                    end
                end
                // Settling slot: the first pixel is presented on the next edge.
                ARM: begin
                    state_q <= en_i_s ? LOAD : IDLE;
                end
                LOAD: begin
                    if (!en_i_s) begin
                        state_q <= IDLE;
                        count_q <= '0;
                    end else begin
                        pix_q[count_q] <= data_i_s;
                        if (count_q == LAST) begin
                            count_q <= '0;
                            state_q <= CALC;
                        end else begin
                            count_q <= count_q + 4'd1;
                        end
                    end
                end
                CALC: begin
                    gx_q    <= signed'(gx_d);
                    gy_q    <= signed'(gy_d);
                    state_q <= MAG;
                end
                MAG: begin
                    data_q  <= mag_d;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    if (!en_i_s) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    count_q <= '0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sobel.sv
// Randomized self-checking bench for sobel against an arithmetic reference model.
module tb_sobel;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] din = 8'd0;
    logic [7:0] dout;
    logic       done;

    int checks = 0;
    int failures = 0;
    int last_out = 0;

    sobel #(
        .KERNEL_MxM  (3),
        .Numb_of_Data(9),
        .THRESHOLD   (128)
    ) dut (
        .clk_i_s   (clk),
        .rstn_i_s  (rst),
        .en_i_s    (en),
        .data_i_s  (din),
        .data_o_s  (dout),
        .sobel_done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int ref_mag(input int p[9]);
        int gx, gy, s;
        gx = (p[2] + 2 * p[5] + p[8]) - (p[0] + 2 * p[3] + p[6]);
        gy = (p[6] + 2 * p[7] + p[8]) - (p[0] + 2 * p[1] + p[2]);
        s  = iabs(gx) + iabs(gy);
`ifdef SOBEL_THRESHOLD_EN
        return (s >= 128) ? 255 : 0;
`else
        return (s > 255) ? 255 : s;
`endif
    endfunction

    // Full window; early_drop releases en right after p8 to show CALC/MAG ignore it.
    task automatic run_window(input string tag, input int p[9], input bit early_drop);
        int exp;
        exp = ref_mag(p);
        en  = 1'b1;
        din = 8'($urandom);
        tick();
        din = 8'($urandom);
        tick();
        for (int i = 0; i < 9; i++) begin
            din = 8'(p[i]);
            tick();
        end
        din = 8'($urandom);
        if (early_drop) en = 1'b0;
        tick();
        chk({tag, "_early_done"}, int'(done), 0);
        chk({tag, "_early_out"}, int'(dout), last_out);
        tick();
        chk({tag, "_done"}, int'(done), 1);
        chk({tag, "_out"}, int'(dout), exp);
        if (!early_drop) begin
            for (int k = 0; k < 2; k++) begin
                tick();
                chk({tag, "_hold_done"}, int'(done), 1);
                chk({tag, "_hold_out"}, int'(dout), exp);
            end
            en = 1'b0;
        end
        tick();
        chk({tag, "_release_done"}, int'(done), 0);
        chk({tag, "_release_out"}, int'(dout), exp);
        last_out = exp;
        tick();
    endtask

    task automatic partial(input int n, input bit do_reset);
        en = 1'b1;
        tick();
        tick();
        for (int i = 0; i < n; i++) begin
            din = 8'($urandom);
            tick();
        end
        if (do_reset) begin
            rst = 1'b1;
            en  = 1'b0;
            tick();
            rst = 1'b0;
            last_out = 0;
            chk("rst_mid_out", int'(dout), 0);
            chk("rst_mid_done", int'(done), 0);
        end else begin
            en = 1'b0;
            tick();
            chk("abort_done", int'(done), 0);
            chk("abort_out", int'(dout), last_out);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle_done", int'(done), 0);
        end
    endtask

    initial begin
        int p[9];
        @(negedge clk);
        tick();
        tick();
        chk("reset_out", int'(dout), 0);
        chk("reset_done", int'(done), 0);
        rst = 1'b0;
        tick();

        p = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_window("zeros", p, 1'b0);
        p = '{0, 0, 10, 0, 0, 10, 0, 0, 10};
        run_window("gx40", p, 1'b0);
        p = '{0, 0, 0, 0, 0, 0, 5, 5, 5};
        run_window("gy20", p, 1'b0);
        p = '{0, 0, 255, 0, 0, 255, 0, 0, 255};
        run_window("gx1020", p, 1'b0);
        p = '{0, 0, 32, 0, 0, 32, 0, 0, 32};
        run_window("s128", p, 1'b0);
        p = '{200, 3, 9, 70, 0, 0, 1, 255, 40};
        run_window("ign_en", p, 1'b1);

        partial(4, 1'b0);
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 9; i++) p[i] = int'($urandom_range(255, 0));
            run_window("rand_seq", p, 1'b0);
        end

        partial(3, 1'b1);
        for (int w = 0; w < 6; w++) begin
            for (int i = 0; i < 9; i++) p[i] = int'($urandom_range(60, 0));
            run_window("rand_small", p, w[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
